prog_mem_fetch: RTL and testbench

Parametrised program memory with a loadable store, a valid/ready fetch port, one-cycle synchronous read and a 2-entry response queue. It sits between the PC/fetch stage and decode. Because the response side can back-pressure, the fetch stage can stall without losing words. Flush support discards stale words after a fork or jump.

---
 rtl/prog_mem_pkg.sv | 26 ++
 rtl/prog_mem_rspq.sv | 65 ++++++
 rtl/prog_mem_fetch.sv | 76 +++++++
 tb/tb_prog_mem_fetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_pkg.sv
// Shared constants and types for the program memory fetch block.
// Holds the HALT opcode encoding, the default out-of-range fetch word,
// the response queue depth and the response entry layout.
package prog_mem_pkg;

    // Default widths; the response entry struct is laid out at these widths.
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;

    // Opcode field occupies the top nibble of an instruction word.
    localparam int          OPC_W    = 4;
    localparam logic [3:0]  OPC_HALT = 4'b1110;

    // Word returned for fetches beyond the implemented depth.
    localparam logic [DATA_W_DEF-1:0] HALT_WORD_DEF = {OPC_HALT, {(DATA_W_DEF-OPC_W){1'b0}}};

    // Response queue capacity.
    localparam int RSPQ_DEPTH = 2;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [ADDR_W_DEF-1:0] addr;
        logic                  err;
    } rsp_entry_t;

endpackage

// File: rtl/prog_mem_rspq.sv
// 2-entry response FIFO with push, pop, flush and an occupancy count.
// Latency: a push is visible on dout the cycle after the edge.
// Backpressure: pushes beyond capacity are dropped (caller gates on count); flush drops all old entries but keeps a same-cycle push.
// Ports: clk, rst (async active-high), push/din, pop, flush, dout (head entry), count.
module prog_mem_rspq
    import prog_mem_pkg::*;
#(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] slot [RSPQ_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign push_ok = push && (count < 2'(RSPQ_DEPTH));
    assign pop_ok  = pop && (count != 2'd0);
    assign dout    = slot[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else if (flush) begin
            // Old entries (including one being popped) are discarded;
            // a surviving push restarts the queue from slot 0.
            rd_ptr <= 1'b0;
            if (push_ok) begin
                slot[0] <= din;
                wr_ptr  <= 1'b1;
                count   <= 2'd1;
            end else begin
                wr_ptr  <= 1'b0;
                count   <= 2'd0;
            end
        end else begin
            if (push_ok) begin
                slot[wr_ptr] <= din;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prog_mem_fetch.sv
// Loadable program memory with a valid/ready fetch port feeding a 2-entry response queue.
// Latency: a request accepted at edge N is presented on rsp_* in the following cycle.
// Backpressure: req_ready drops while loading, in reset, or with the queue full; rsp_* hold while stalled.
// Ports: load port (ld_en/ld_addr/ld_data), fetch request (req_valid/req_addr/req_ready),
//        response (rsp_valid/rsp_ready/rsp_data/rsp_addr/rsp_err), flush.
module prog_mem_fetch
    import prog_mem_pkg::*;
#(
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 10,
    parameter int                 DEPTH     = 1024,
    parameter logic [DATA_W-1:0]  HALT_WORD = HALT_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    input  logic              flush
);

    localparam int              ENTRY_W = DATA_W + ADDR_W + 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0]  mem [DEPTH];
    logic               ld_in_range;
    logic               req_in_range;
    logic               accept;
    logic [DATA_W-1:0]  rd_word;
    logic [ENTRY_W-1:0] q_din;
    logic [ENTRY_W-1:0] q_dout;
    logic [1:0]         q_count;

    assign ld_in_range  = {1'b0, ld_addr}  < DEPTH_L;
    assign req_in_range = {1'b0, req_addr} < DEPTH_L;

    // Storage is not reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (ld_en && ld_in_range) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // A load blocks accepts, so the array is never read and written together.
    assign req_ready = !rst && !ld_en && (q_count < 2'(RSPQ_DEPTH));
    assign accept    = req_valid && req_ready;

    assign rd_word = req_in_range ? mem[req_addr] : HALT_WORD;
    assign q_din   = {rd_word, req_addr, !req_in_range};

    prog_mem_rspq #(
        .W (ENTRY_W)
    ) u_rspq (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (q_din),
        .pop   (rsp_valid && rsp_ready),
        .flush (flush),
        .dout  (q_dout),
        .count (q_count)
    );

    assign rsp_valid                     = (q_count != 2'd0);
    assign {rsp_data, rsp_addr, rsp_err} = q_dout;

endmodule

// File: tb/tb_prog_mem_fetch.sv
module tb_prog_mem_fetch;
    import prog_mem_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          rsp_err;
    logic          flush = 1'b0;

    prog_mem_fetch #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Reference model: contents of the response queue and of the memory.
    rsp_entry_t    q[$];
    logic [DW-1:0] mmem [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("req_ready", 32'(req_ready), 32'(!ld_en && (q.size() < 2)));
            chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
                chk("rsp_addr", 32'(rsp_addr), 32'(q[0].addr));
                chk("rsp_err",  32'(rsp_err),  32'(q[0].err));
            end
        end
    end

    // Advance the model across one rising edge using the inputs held there.
    task automatic model_edge();
        bit         acc;
        bit         pop;
        rsp_entry_t e;
        acc = req_valid && !ld_en && (q.size() < 2);
        pop = rsp_ready && (q.size() != 0);
        e.addr = req_addr;
        if (int'(req_addr) < DEPTH) begin
            e.data = mmem[req_addr];
            e.err  = 1'b0;
        end else begin
            e.data = 16'hE000;
            e.err  = 1'b1;
        end
        if (flush) q.delete();
        else if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
        if (ld_en && int'(ld_addr) < DEPTH) mmem[ld_addr] = ld_data;
    endtask

    task automatic step(input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                        input bit rv, input logic [AW-1:0] ra, input bit rr, input bit fl);
        ld_en     = lv;
        ld_addr   = la;
        ld_data   = ld;
        req_valid = rv;
        req_addr  = ra;
        rsp_ready = rr;
        flush     = fl;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input bit rr);
        step(1'b0, '0, '0, 1'b1, a, rr, 1'b0);
    endtask

    task automatic idle(input bit rr);
        step(1'b0, '0, '0, 1'b0, '0, rr, 1'b0);
    endtask

    logic [DW-1:0] prog [4] = '{16'hD244, 16'hC240, 16'hD202, 16'hB040};

    initial begin
        // Reset values
        #3;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_rsp_addr",  32'(rsp_addr),  32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("req_ready_after_rst", 32'(req_ready), 32'd1);

        // Fill the whole array, then the small program
        for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), 16'($urandom), 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, AW'(i), prog[i], 1'b0, '0, 1'b0, 1'b0);

        // Back-to-back fetch, one word per cycle
        for (int i = 0; i < 4; i++) begin
            fetch(AW'(i), 1'b1);
            chk("prog_data", 32'(rsp_data), 32'(prog[i]));
            chk("prog_addr", 32'(rsp_addr), i);
            chk("prog_err",  32'(rsp_err),  32'd0);
        end
        idle(1'b1);

        // Back-pressure: 5 and 6 fill the queue, 7 waits
        fetch(10'd5, 1'b0);
        fetch(10'd6, 1'b0);
        chk("bp_full_ready", 32'(req_ready), 32'd0);
        fetch(10'd7, 1'b0);
        chk("bp_head_hold", 32'(rsp_addr), 32'd5);
        fetch(10'd7, 1'b1);
        chk("bp_pop5_head", 32'(rsp_addr), 32'd6);
        chk("bp_ready_back", 32'(req_ready), 32'd1);
        fetch(10'd7, 1'b1);
        chk("bp_accept7", 32'(rsp_addr), 32'd7);
        idle(1'b1);
        chk("bp_drained", 32'(rsp_valid), 32'd0);

        // Flush of a full queue with nothing accepted
        fetch(10'd8, 1'b0);
        fetch(10'd9, 1'b0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        chk("flush_empty", 32'(rsp_valid), 32'd0);
        // Flush with a same-cycle pop and accept of 24
        fetch(10'd8, 1'b0);
        step(1'b0, '0, '0, 1'b1, 10'd24, 1'b1, 1'b1);
        chk("flush_keep_addr", 32'(rsp_addr), 32'd24);
        chk("flush_keep_err",  32'(rsp_err),  32'd1);
        idle(1'b0);
        chk("flush_count1", 32'(rsp_addr), 32'd24);
        idle(1'b1);
        chk("flush_no_stale", 32'(rsp_valid), 32'd0);

        // Out-of-range fetch and load
        fetch(10'd25, 1'b0);
        chk("oor_data", 32'(rsp_data), 32'hE000);
        chk("oor_err",  32'(rsp_err),  32'd1);
        idle(1'b1);
        step(1'b1, 10'd25, 16'hFFFF, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            fetch(AW'(i), 1'b1);
            if (i == 0) chk("oor_load_mem0", 32'(rsp_data), 32'hD244);
        end
        idle(1'b1);

        // Loads block accepts
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 10'd2, 16'h1234, 1'b1, 10'd2, 1'b1, 1'b0);
            chk("ld_blocks_ready", 32'(req_ready), 32'd0);
            chk("ld_no_accept", 32'(rsp_valid), 32'd0);
        end
        fetch(10'd2, 1'b1);
        chk("refetch_new", 32'(rsp_data), 32'h1234);
        idle(1'b1);

        // Asynchronous reset with two entries queued
        fetch(10'd1, 1'b0);
        fetch(10'd3, 1'b0);
        #1;
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("arst_valid", 32'(rsp_valid), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        q.delete();
        @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;
        fetch(10'd0, 1'b1);
        chk("arst_mem_kept", 32'(rsp_data), 32'hD244);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) == 0, AW'($urandom_range(0, 31)), 16'($urandom),
                 $urandom_range(0, 9) < 7, AW'($urandom_range(0, 31)),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        idle(1'b1);
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
